// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined, multi-cycle memory between the I-cache
// fill FSM and the D-cache (block fills plus single-word write-through
// stores). It issues the word addresses for a granted fill, routes returning
// data strobes to the owner, and holds the losing side off with wait lines.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_wr,
  input  logic [15:0] d_waddr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        i_wait,
  output logic        d_wait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_STORE = 2'd3
  } state_e;

  // Counters are 4 bits wide, so a block may hold at most 15 words; a return
  // must also trail its issue by at least one cycle for completion to imply
  // that every word has been issued.
  localparam logic [3:0] WORDS_C  = 4'(WORDS);
  localparam logic [3:0] LAST_RET = 4'(WORDS - 1);

  if (LATENCY < 1 || WORDS < 1 || WORDS > 15) begin : g_bad_params
    $error("mem_arbiter: LATENCY must be >= 1 and WORDS within 1..15");
  end

  state_e      state_q;
  logic [3:0]  issue_q;
  logic [3:0]  ret_q;
  logic [15:0] base_q;
  logic        last_d_q;     // 1'b1: the last completed fill belonged to D
  logic        mem_en_q;
  logic        mem_wr_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;

  logic        grant_i;
  logic        grant_d;
  logic        grant_st;

  // IDLE arbitration: stores first, then fills with alternating priority on a tie.
  always_comb begin
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    grant_st = 1'b0;
    if (state_q == IDLE) begin
      if (d_wr) begin
        grant_st = 1'b1;
      end else if (i_req && d_req) begin
        if (last_d_q) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b0;
      end
    end else begin
      grant_st = 1'b0;
    end
  end

  // Ownership FSM with registered memory-side outputs and fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_q     <= 4'd0;
      ret_q       <= 4'd0;
      base_q      <= 16'h0000;
      last_d_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          issue_q  <= 4'd0;
          ret_q    <= 4'd0;
          if (grant_st) begin
            state_q     <= D_STORE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= d_waddr;
            mem_wdata_q <= d_wdata;
          end else if (grant_i) begin
            // Word 0 goes out in the first fill cycle.
            state_q    <= I_FILL;
            base_q     <= i_addr & 16'hFFF0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= i_addr & 16'hFFF0;
            issue_q    <= 4'd1;
          end else if (grant_d) begin
            state_q    <= D_FILL;
            base_q     <= d_addr & 16'hFFF0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= d_addr & 16'hFFF0;
            issue_q    <= 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        I_FILL, D_FILL: begin
          mem_wr_q <= 1'b0;
          if (issue_q < WORDS_C) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= base_q | {11'd0, issue_q, 1'b0};
            issue_q    <= issue_q + 4'd1;
          end else begin
            mem_en_q <= 1'b0;
          end
          if (mem_data_valid) begin
            if (ret_q == LAST_RET) begin
              state_q  <= IDLE;
              mem_en_q <= 1'b0;
              ret_q    <= 4'd0;
              issue_q  <= 4'd0;
              last_d_q <= (state_q == D_FILL);
            end else begin
              ret_q <= ret_q + 4'd1;
            end
          end else begin
            ret_q <= ret_q;
          end
        end
        D_STORE: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Returning data only reaches a cache that owns a fill; strays are dropped.
  assign i_data_valid = mem_data_valid && (state_q == I_FILL);
  assign d_data_valid = mem_data_valid && (state_q == D_FILL);

  assign i_wait = (state_q == D_FILL) || (state_q == D_STORE) || grant_d || grant_st;
  assign d_wait = (state_q == I_FILL) || grant_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-LATENCY memory responder, a
// transaction-level ownership model checked every cycle, and literal
// expectations for the address streams and pulse counts of each scenario.
module tb_mem_arbiter;

  localparam int LATENCY = 4;
  localparam int WORDS   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_waddr, d_wdata;
  bit          mdv;
  logic        mem_en, mem_wr, i_data_valid, d_data_valid, i_wait, d_wait;
  logic [15:0] mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.LATENCY(LATENCY), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr),
    .d_wr(d_wr), .d_waddr(d_waddr), .d_wdata(d_wdata),
    .mem_data_valid(mdv),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_wait(i_wait), .d_wait(d_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: each read issue returns a valid strobe LATENCY cycles later.
  bit [LATENCY-1:0] hist;
  always @(negedge clk) hist <= {hist[LATENCY-2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
  always @(posedge clk) mdv <= hist[LATENCY-1];

  // Ownership model: who holds memory and how far the current transaction has run.
  typedef enum int {O_NONE, O_I, O_D, O_ST} own_e;
  own_e        m_own = O_NONE;
  int          m_t, m_rets;
  bit          m_last_d;
  logic [15:0] m_base, m_sa, m_sd;

  // Scenario logs filled by the compare process.
  logic [15:0] addr_log[$];
  int st_cnt, idv_cnt, ddv_cnt, iw_cnt, dw_cnt, mdv_cnt;
  logic [15:0] st_addr, st_data;

  function automatic own_e pick();
    if (d_wr) return O_ST;
    if (i_req && d_req) return m_last_d ? O_I : O_D;
    if (i_req) return O_I;
    if (d_req) return O_D;
    return O_NONE;
  endfunction

  // Per-cycle compare against the model, then advance the model for the next edge.
  always @(negedge clk) begin : cmp
    logic e_en, e_wr, e_idv, e_ddv, e_iw, e_dw;
    logic [15:0] e_addr, e_wd;
    own_e sel;
    if (mdv) mdv_cnt++;
    if (!rst_n) begin
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_i_dv", 32'(i_data_valid), 32'd0);
      chk("rst_d_dv", 32'(d_data_valid), 32'd0);
      chk("rst_i_wait", 32'(i_wait), 32'd0);
      chk("rst_d_wait", 32'(d_wait), 32'd0);
      m_own = O_NONE; m_last_d = 1'b0; m_t = 0; m_rets = 0;
    end else begin
      sel = pick();
      e_en = 1'b0; e_wr = 1'b0; e_idv = 1'b0; e_ddv = 1'b0; e_iw = 1'b0; e_dw = 1'b0;
      e_addr = 16'h0000; e_wd = 16'h0000;
      case (m_own)
        O_NONE: begin
          e_iw = (sel == O_D) || (sel == O_ST);
          e_dw = (sel == O_I);
        end
        O_ST: begin
          e_en = 1'b1; e_wr = 1'b1; e_addr = m_sa; e_wd = m_sd; e_iw = 1'b1;
        end
        default: begin
          e_en   = (m_t < WORDS);
          e_addr = m_base + 16'(2 * m_t);
          e_idv  = (m_own == O_I) && mdv;
          e_ddv  = (m_own == O_D) && mdv;
          e_iw   = (m_own == O_D);
          e_dw   = (m_own == O_I);
        end
      endcase
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("i_data_valid", 32'(i_data_valid), 32'(e_idv));
      chk("d_data_valid", 32'(d_data_valid), 32'(e_ddv));
      chk("i_wait", 32'(i_wait), 32'(e_iw));
      chk("d_wait", 32'(d_wait), 32'(e_dw));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));

      if (mem_en === 1'b1 && mem_wr === 1'b0) addr_log.push_back(mem_addr);
      if (mem_en === 1'b1 && mem_wr === 1'b1) begin
        st_cnt++; st_addr = mem_addr; st_data = mem_wdata;
      end
      if (i_data_valid) idv_cnt++;
      if (d_data_valid) ddv_cnt++;
      if (i_wait) iw_cnt++;
      if (d_wait) dw_cnt++;

      case (m_own)
        O_NONE: begin
          m_own = sel; m_t = 0; m_rets = 0;
          if (sel == O_ST) begin m_sa = d_waddr; m_sd = d_wdata; end
          if (sel == O_I) m_base = i_addr & 16'hFFF0;
          if (sel == O_D) m_base = d_addr & 16'hFFF0;
        end
        O_ST: m_own = O_NONE;
        default: begin
          m_t++;
          if (mdv) begin
            m_rets++;
            if (m_rets == WORDS) begin
              m_last_d = (m_own == O_D);
              m_own = O_NONE;
            end
          end
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    st_cnt = 0; idv_cnt = 0; ddv_cnt = 0; iw_cnt = 0; dw_cnt = 0; mdv_cnt = 0;
  endtask

  // Literal block check: eight consecutive word addresses starting at 'first'.
  task automatic chk_block(input string tag, input int at, input logic [15:0] first);
    for (int k = 0; k < WORDS; k++)
      chk($sformatf("%s_addr%0d", tag, k), 32'(addr_log[at + k]), 32'(first + 16'(2 * k)));
  endtask

  initial begin
    logic [15:0] t1_exp [8];
    t1_exp = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
               16'h1238, 16'h123A, 16'h123C, 16'h123E};
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; d_waddr = 16'h0000; d_wdata = 16'h0000;
    clear_logs();
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // I-only fill from 16'h1236.
    clear_logs();
    i_req = 1'b1; i_addr = 16'h1236;
    cyc(1); i_req = 1'b0;
    cyc(13);
    chk("t1_issues", 32'(addr_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_addr%0d", k), 32'(addr_log[k]), 32'(t1_exp[k]));
    chk("t1_i_dv", 32'(idv_cnt), 32'd8);
    chk("t1_d_dv", 32'(ddv_cnt), 32'd0);
    chk("t1_d_wait", 32'(dw_cnt), 32'd13);   // grant cycle in IDLE plus 12 fill cycles

    // Simultaneous requests from reset: D wins, I follows.
    clear_logs();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h5678; d_addr = 16'h4010;
    cyc(1); d_req = 1'b0;
    cyc(13); i_req = 1'b0;
    cyc(14);
    chk("t2_issues", 32'(addr_log.size()), 32'd16);
    chk_block("t2_d", 0, 16'h4010);
    chk_block("t2_i", 8, 16'h5670);
    chk("t2_i_wait", 32'(iw_cnt), 32'd13);
    chk("t2_d_dv", 32'(ddv_cnt), 32'd8);
    chk("t2_i_dv", 32'(idv_cnt), 32'd8);

    // Store beats a pending I request.
    clear_logs();
    d_wr = 1'b1; d_waddr = 16'h8000; d_wdata = 16'hBEEF; i_req = 1'b1; i_addr = 16'h2000;
    cyc(1); d_wr = 1'b0;
    cyc(2); i_req = 1'b0;
    cyc(14);
    chk("t3_stores", 32'(st_cnt), 32'd1);
    chk("t3_st_addr", 32'(st_addr), 32'h8000);
    chk("t3_st_data", 32'(st_data), 32'hBEEF);
    chk("t3_issues", 32'(addr_log.size()), 32'd8);
    chk_block("t3_i", 0, 16'h2000);

    // D request arrives during I fill word 3 and waits.
    clear_logs();
    i_req = 1'b1; i_addr = 16'h3ABC;
    cyc(1); i_req = 1'b0;
    cyc(3); d_req = 1'b1; d_addr = 16'h7001;
    cyc(10); d_req = 1'b0;
    cyc(14);
    chk("t4_issues", 32'(addr_log.size()), 32'd16);
    chk_block("t4_i", 0, 16'h3AB0);
    chk_block("t4_d", 8, 16'h7000);
    chk("t4_d_wait", 32'(dw_cnt), 32'd13);

    // Tie after a D fill: I wins this time.
    clear_logs();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h1111; d_addr = 16'h2222;
    cyc(1); i_req = 1'b0;
    cyc(13); d_req = 1'b0;
    cyc(14);
    chk("t5_issues", 32'(addr_log.size()), 32'd16);
    chk_block("t5_i", 0, 16'h1110);
    chk_block("t5_d", 8, 16'h2220);

    // Reset at the fifth return of a D fill.
    clear_logs();
    d_req = 1'b1; d_addr = 16'h9A5C;
    cyc(1); d_req = 1'b0;
    cyc(8);
    chk("t6_d_dv_before", 32'(ddv_cnt), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_imm_mem_en", 32'(mem_en), 32'd0);
    chk("t6_imm_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_imm_d_wait", 32'(d_wait), 32'd0);
    chk("t6_imm_i_wait", 32'(i_wait), 32'd0);
    ddv_cnt = 0; mdv_cnt = 0;
    cyc(2); rst_n = 1'b1;
    cyc(4);
    chk("t6_late_mdv", 32'(mdv_cnt), 32'd4);
    chk("t6_late_d_dv", 32'(ddv_cnt), 32'd0);
    clear_logs();
    i_req = 1'b1; i_addr = 16'hC0DE;
    cyc(1); i_req = 1'b0;
    cyc(14);
    chk("t6_issues", 32'(addr_log.size()), 32'd8);
    chk_block("t6_i", 0, 16'hC0D0);
    chk("t6_i_dv", 32'(idv_cnt), 32'd8);

    // I request dropped after two issues; the fill still completes.
    clear_logs();
    i_req = 1'b1; i_addr = 16'hFFFF;
    cyc(3); i_req = 1'b0;
    cyc(13);
    chk("t7_issues", 32'(addr_log.size()), 32'd8);
    chk_block("t7_i", 0, 16'hFFF0);
    chk("t7_i_dv", 32'(idv_cnt), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single multi-cycle unified memory between the I-cache fill FSM and the D-cache (fill FSM plus write-through stores). Sits directly downstream of both cache fill FSMs: it issues the word addresses for a granted block fill, routes the memory data-valid strobe back to the owning cache, and drives the per-cache wait lines that hold an FSM idle while the other side owns memory.

## Interface
- LATENCY, 4, memory read latency in cycles from `mem_en` to `mem_data_valid` (reads are pipelined, one issue per cycle)
- WORDS, 8, 16-bit words per cache block (16-byte blocks)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  I-cache fill request (I fill FSM busy)
- i_addr  in  16  I-cache miss address
- d_req  in  1  D-cache fill request
- d_addr  in  16  D-cache miss address
- d_wr  in  1  D-cache write-through store request (single word)
- d_waddr  in  16  store address
- d_wdata  in  16  store data
- mem_data_valid  in  1  memory read data valid
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (valid with `mem_en`)
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- i_data_valid  out  1  data valid routed to I-cache
- d_data_valid  out  1  data valid routed to D-cache
- i_wait  out  1  I side must not consume memory data
- d_wait  out  1  D side must not consume memory data

## Operation
- States: IDLE, I_FILL, D_FILL, D_STORE.
- IDLE arbitration: `d_wr` highest (-> D_STORE). Otherwise one of `i_req`/`d_req` -> matching fill state. If both are requested, the side not granted last time wins; `last_grant` resets to I, so D wins the first tie.
- D_STORE: one cycle, `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_waddr`, `mem_wdata`=`d_wdata`; then IDLE.
- Fill states:
  - base = addr & 16'hFFF0, latched on entry.
  - Issue counter (4 bit) drives `mem_en`=1, `mem_wr`=0, `mem_addr` = base | {idx,1'b0} for idx 0..WORDS-1, one per cycle.
  - Return counter (4 bit) increments on each `mem_data_valid`.
  - When the return count reaches WORDS, go to IDLE and set `last_grant`.
- `i_data_valid` = `mem_data_valid` & (state==I_FILL). `d_data_valid` = `mem_data_valid` & (state==D_FILL). Both are combinational.
- `i_wait` = state ∈ {D_FILL, D_STORE} or (IDLE and D selected this cycle). `d_wait` is symmetric for I_FILL.
- A request dropped mid-fill is ignored; the fill always completes WORDS returns.
- `mem_data_valid` in IDLE or D_STORE is dropped: no valid is routed and no counter changes.
- `mem_data_valid` beyond WORDS cannot occur; if it does, it is ignored.
- A new request during a fill waits; it is re-arbitrated in IDLE.

## Timing
- Reset (async, immediate) forces:
  - state=IDLE, counters=0, `last_grant`=I;
  - all outputs 0 (`mem_addr`/`mem_wdata` = 16'h0000, `i_wait`=`d_wait`=0).
- Reset mid-fill abandons the fill; memory data returning afterwards is dropped.
- Request high in IDLE at edge N -> fill state from edge N. Word 0 issues in cycle N..N+1, words issue on consecutive cycles through word WORDS-1.
- Word k data valid is at issue+LATENCY. Last valid is in cycle N+WORDS-1+LATENCY; IDLE from the following edge.
- Fill occupancy = WORDS+LATENCY cycles (12 by default). A back-to-back grant can start the cycle after return to IDLE.
- Store occupancy = 1 cycle; the store is complete at the edge ending D_STORE.
- `mem_en` is low on every non-issue cycle, including the LATENCY drain cycles.

## Test plan
- I-only fill, i_addr=16'h1236 -> mem_addr sequence 1230,1232,…,123E on 8 consecutive cycles; 8 `i_data_valid` pulses; `d_data_valid`=0 and `d_wait`=1 throughout; IDLE after 12 cycles.
- `i_req` and `d_req` rise in the same cycle from reset -> D fills first from d_addr=16'h4010, `i_wait`=1 for 12 cycles; I fill from i_addr base then starts.
- `d_wr` with addr 16'h8000, data 16'hBEEF while `i_req`=1 in IDLE -> one cycle `mem_en`=`mem_wr`=1 with 8000/BEEF; I fill starts the next cycle.
- `d_req` asserted during I fill word 3 -> D fill waits; `d_wait`=1 until I completes; D fill starts the first IDLE cycle.
- `rst_n` low at return 5 of a D fill -> outputs 0 immediately; late `mem_data_valid` pulses produce no `d_data_valid`; a fresh `i_req` after release fills normally.
- `i_req` dropped after 2 issues -> all 8 addresses still issued; 8 `i_data_valid` pulses.
